// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: FSM encodings, default reset PC / increment and word alignment.
package fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_INC   = 4;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Issue register plus one-entry prefetch skid; a push lands in the issue slot only when
// that slot is free (or draining) and the skid is empty, so program order is preserved.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_iss_vld,
  output logic [DATA_W-1:0] o_iss_dat,
  output logic [ADDR_W-1:0] o_iss_pc,
  output logic              o_pf_vld
);

  logic              r_iss_vld;
  logic [DATA_W-1:0] r_iss_dat;
  logic [ADDR_W-1:0] r_iss_pc;
  logic              r_pf_vld;
  logic [DATA_W-1:0] r_pf_dat;
  logic [ADDR_W-1:0] r_pf_pc;

  logic w_push_iss;
  logic w_push_pf;

  assign w_push_iss = i_push & (~r_iss_vld | i_pop) & ~r_pf_vld;
  assign w_push_pf  = i_push & ~w_push_iss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_vld <= 1'b0;
      r_iss_dat <= '0;
      r_iss_pc  <= '0;
      r_pf_vld  <= 1'b0;
      r_pf_dat  <= '0;
      r_pf_pc   <= '0;
    end else if (i_flush) begin
      r_iss_vld <= 1'b0;
      r_pf_vld  <= 1'b0;
    end else begin
      if (w_push_iss) begin
        r_iss_vld <= 1'b1;
        r_iss_dat <= i_push_dat;
        r_iss_pc  <= i_push_pc;
      end else if (i_pop && r_pf_vld) begin
        r_iss_vld <= 1'b1;
        r_iss_dat <= r_pf_dat;
        r_iss_pc  <= r_pf_pc;
      end else if (i_pop) begin
        r_iss_vld <= 1'b0;
      end

      if (w_push_pf) begin
        r_pf_vld <= 1'b1;
        r_pf_dat <= i_push_dat;
        r_pf_pc  <= i_push_pc;
      end else if (i_pop) begin
        r_pf_vld <= 1'b0;
      end
    end
  end

  assign o_iss_vld = r_iss_vld;
  assign o_iss_dat = r_iss_dat;
  assign o_iss_pc  = r_iss_pc;
  assign o_pf_vld  = r_pf_vld;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC sequencing, instruction-memory handshake, branch redirect with stale-fetch drop.
// Define FETCH_STATS_EN to add the fetch_cnt / flush_cnt statistics outputs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_INC   = DEF_PC_INC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] INC    = ADDR_W'(PC_INC);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_drop_addr;

  logic              w_consume;
  logic              w_redirect;
  logic              w_accept;
  logic              w_pop;
  logic              w_pf_vld;
  logic [1:0]        w_occ_nxt;
  logic              w_full_nxt;
  logic [ADDR_W-1:0] w_target;

  assign w_consume  = instr_valid & ~stall;
  assign w_redirect = w_consume & branch_taken;
  assign w_accept   = (r_state == S_FETCH) & imem_valid & ~w_redirect;
  assign w_pop      = w_consume & ~w_redirect;
  assign w_target   = ADDR_W'(align_word(32'(branch_target)));

  // Occupancy after this cycle's push/pop decides whether another fetch may be issued.
  assign w_occ_nxt  = 2'(instr_valid) + 2'(w_pf_vld) + 2'(w_accept) - 2'(w_pop);
  assign w_full_nxt = (w_occ_nxt == 2'd2);

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_push_dat (imem_rdata),
    .i_push_pc  (r_fetch_pc),
    .i_pop      (w_pop),
    .i_flush    (w_redirect),
    .o_iss_vld  (instr_valid),
    .o_iss_dat  (instr),
    .o_iss_pc   (instr_pc),
    .o_pf_vld   (w_pf_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RST_PC;
      r_drop_addr <= RST_PC;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            if (!imem_valid) begin
              r_state     <= S_DROP;
              r_drop_addr <= r_fetch_pc;
            end
          end else if (imem_valid) begin
            r_fetch_pc <= r_fetch_pc + INC;
            r_state    <= w_full_nxt ? S_WAIT : S_FETCH;
          end
        end
        S_WAIT: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_state    <= S_FETCH;
          end else if (w_consume) begin
            r_state <= S_FETCH;
          end
        end
        S_DROP: if (imem_valid) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // DROP keeps presenting the abandoned address until its response retires.
  assign imem_req  = (r_state == S_FETCH) | (r_state == S_DROP);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_fetch_pc;
  assign pc_plus8  = instr_pc + ADDR_W'(8);

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_accept)   r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_redirect) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit against a variable-latency instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic        instr_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
  int          vpulses = 0;
  int          vp0 = 0;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus8      (pc_plus8),
    .instr_valid   (instr_valid)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_C3F0;
  endfunction

  // Memory answers after `lat` cycles of a held request (lat=0 is zero-wait).
  int lat = 0;
  int lat_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) lat_cnt <= 0;
    else     lat_cnt <= (imem_req && !imem_valid) ? lat_cnt + 1 : 0;
  end
  assign imem_valid = imem_req && (lat_cnt >= lat);
  assign imem_rdata = mem_word(imem_addr);

`ifdef FETCH_STATS_EN
  always @(posedge clk) if (!rst && imem_valid) vpulses++;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Every consumed instruction must be the next expected PC, in order.
  always @(negedge clk) begin
    #1;
    if (!rst && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_pc", instr_pc, mon_e);
        check_eq("sb_instr", instr, mem_word(mon_e));
        check_eq("sb_pc8", pc_plus8, mon_e + 32'd8);
      end
    end
  end

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_req"}, 32'(imem_req), 32'd0);
    check_eq({pfx, "_addr"}, imem_addr, 32'd0);
    check_eq({pfx, "_instr"}, instr, 32'd0);
    check_eq({pfx, "_pc"}, instr_pc, 32'd0);
    check_eq({pfx, "_pc8"}, pc_plus8, 32'd8);
    check_eq({pfx, "_vld"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string tag);
    int n = 0;
    while (!(instr_valid && instr_pc == pc) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq({tag, "_timeout"}, instr_pc, pc);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    stall = 1'b1;
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int          req_cnt;
    int          n;
    logic [31:0] last_addr;

    // Sequential fetch with zero-wait memory.
    repeat (2) @(negedge clk);
    check_reset("rst");
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0;
    #1;
    check_eq("req_at_release", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, 32'd0);
    check_eq("vld_before_resp", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check_eq("vld_after_resp", 32'(instr_valid), 32'd1);

    // Hold at PC 8: only the word at 12 may be prefetched, then requests stop.
    wait_pc(32'h8, "wait_pc8");
    stall     = 1'b1;
    req_cnt   = 0;
    last_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (imem_req) begin
        req_cnt++;
        last_addr = imem_addr;
      end
      check_eq("stall_hold_pc", instr_pc, 32'h8);
      @(negedge clk);
    end
    check_eq("stall_prefetch_cnt", 32'(req_cnt), 32'd1);
    check_eq("stall_prefetch_addr", last_addr, 32'hC);
    check_eq("wait_no_req", 32'(imem_req), 32'd0);
    stall = 1'b0;

    // Asynchronous reset while a fetch is in flight.
    wait_pc(32'h14, "wait_pc20");
    check_eq("midfetch_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    exp_q.delete();

    // Redirect taken with a same-cycle response: that word and its successor never issue.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("post_rst_addr", imem_addr, 32'h0);
    wait_pc(32'h4, "wait_pc4");
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    @(negedge clk);
    branch_taken = 1'b0;
    check_eq("redir_req", 32'(imem_req), 32'd1);
    check_eq("redir_addr", imem_addr, 32'h100);
    check_eq("redir_flush", 32'(instr_valid), 32'd0);
    wait_drain("redir");

    // Two-cycle memory: redirect while a request is outstanding must drop the late word.
    rst   = 1'b1;
    stall = 1'b0;
    lat   = 2;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    @(negedge clk);
    rst = 1'b0;
`ifdef FETCH_STATS_EN
    vp0 = vpulses;
`endif
    wait_pc(32'h0, "wait_lat_pc0");
    check_eq("drop_outstanding", 32'(imem_valid), 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    check_eq("drop_req", 32'(imem_req), 32'd1);
    check_eq("drop_hold_addr", imem_addr, 32'h4);
    n = 0;
    while (imem_addr == 32'h4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("drop_next_addr", imem_addr, 32'h40);
    check_eq("drop_next_req", 32'(imem_req), 32'd1);
    wait_drain("drop");

`ifdef FETCH_STATS_EN
    check_eq("stat_flush", flush_cnt, 32'd1);
    check_eq("stat_fetch", fetch_cnt, 32'(vpulses - vp0 - 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
